// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: multicycle RV32I main control (lw, sw, R, I-ALU, beq, jal) with memory-ready stalls.
// Define CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes in TRAP; otherwise they retire as NOPs.
module multicycle_ctrl_fsm #(
  parameter int RESET_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       mem_req,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal
);
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
`ifdef CTRL_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam state_t S_BAD = S_TRAP;
`else
  localparam state_t S_BAD = S_FETCH;
`endif

  state_t     r_state;
  logic [3:0] r_hold;
  state_t     w_dec_next;
  logic [1:0] w_imm;
  logic [2:0] w_alu;

  assign w_dec_next = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                      (op == OP_R)   ? S_EXECR :
                      (op == OP_I)   ? S_EXECI :
                      (op == OP_BEQ) ? S_BEQ   :
                      (op == OP_JAL) ? S_JAL   : S_BAD;

  assign w_imm = (op == OP_SW)  ? 2'b01 :
                 (op == OP_BEQ) ? 2'b10 :
                 (op == OP_JAL) ? 2'b11 : 2'b00;

  // funct7b5 selects sub only for register-register ops; I-type bit 30 is immediate data
  assign w_alu = (funct3 == 3'b000) ? ((r_state == S_EXECR && funct7b5) ? 3'b001 : 3'b000) :
                 (funct3 == 3'b010) ? 3'b101 :
                 (funct3 == 3'b110) ? 3'b011 :
                 (funct3 == 3'b111) ? 3'b010 : 3'b000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RST;
      r_hold  <= '0;
    end else begin
      case (r_state)
        S_RST:      if (r_hold == 4'(RESET_HOLD)) r_state <= S_FETCH;
                    else r_hold <= r_hold + 4'd1;
        S_FETCH:    if (mem_ready) r_state <= S_DECODE;
        S_DECODE:   r_state <= w_dec_next;
        S_MEMADR:   r_state <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
        S_MEMWB:    r_state <= S_FETCH;
        S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
        S_EXECR:    r_state <= S_ALUWB;
        S_EXECI:    r_state <= S_ALUWB;
        S_ALUWB:    r_state <= S_FETCH;
        S_BEQ:      r_state <= S_FETCH;
        S_JAL:      r_state <= S_ALUWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
        S_TRAP:     r_state <= S_TRAP;
`endif
        default:    r_state <= S_RST;
      endcase
    end
  end

  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    mem_req     = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    illegal     = 1'b0;
    imm_src     = (r_state == S_RST) ? 2'b00 : w_imm;
    case (r_state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = w_alu;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = w_alu;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = 3'b001;
        pc_write    = zero;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        imm_src = 2'b00;
        illegal = 1'b1;
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: random instruction stream checked cycle by cycle against a per-instruction step table.
module tb_multicycle_ctrl_fsm;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic funct7b5 = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic pc_write, adr_src, mem_write, mem_req, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [17:0] w_obs;
  int n_chk = 0, n_pass = 0;

  multicycle_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .mem_req(mem_req), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign w_obs = {pc_write, adr_src, mem_write, mem_req, ir_write, reg_write,
                  result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal};

  function automatic logic [17:0] vec(logic pw, logic as, logic mw, logic mr, logic iw, logic rw,
                                      logic [1:0] rs, logic [1:0] a, logic [1:0] b, logic [1:0] im,
                                      logic [2:0] alu, logic ill);
    return {pw, as, mw, mr, iw, rw, rs, a, b, im, alu, ill};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] imm_of(logic [6:0] o);
    return (o == SW) ? 2'b01 : (o == BQ) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
  endfunction

  function automatic logic [2:0] alu_of(logic is_r, logic [2:0] f3, logic f7);
    case (f3)
      3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic is_legal(logic [6:0] o);
    return o == LW || o == SW || o == RT || o == IT || o == BQ || o == JL;
  endfunction

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
  endtask

  // entered at a falling edge; leaves at the next falling edge
  task automatic step(input string tag, input logic rdy, input logic z, input logic [17:0] exp);
    mem_ready = rdy;
    zero = z;
    #1 chk(tag, w_obs, exp);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1 chk("rst_async", w_obs, '0);
    @(negedge clk);
    step("rst_low", 1'b1, rb(), '0);
    rst_n = 1'b1;
    step("rst_hold0", 1'b1, rb(), '0);
    step("rst_hold1", 1'b1, rb(), '0);
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int fw, input int mw);
    logic [1:0] im;
    logic r;
    op = o;
    funct3 = f3;
    funct7b5 = f7;
    im = imm_of(o);
    for (int w = 0; w <= fw; w++) begin
      r = (w == fw);
      step("fetch", r, rb(), vec(r, 0, 0, 1, r, 0, 2'b10, 2'b00, 2'b10, im, 3'b000, 0));
    end
    step("decode", rb(), rb(), vec(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, 3'b000, 0));
    case (o)
      LW, SW: begin
        step("memadr", rb(), rb(), vec(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 3'b000, 0));
        for (int w = 0; w <= mw; w++) begin
          r = (w == mw);
          if (o == LW) step("memread", r, rb(), vec(0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0));
          else step("memwrite", r, rb(), vec(0, 1, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0));
        end
        if (o == LW) step("memwb", rb(), rb(), vec(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, im, 3'b000, 0));
      end
      RT, IT: begin
        step("exec", rb(), rb(), vec(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, (o == RT) ? 2'b00 : 2'b01, im,
                                     alu_of(o == RT, f3, f7), 0));
        step("aluwb", rb(), rb(), vec(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 3'b000, 0));
      end
      BQ: step("beq", rb(), z, vec(z, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, im, 3'b001, 0));
      JL: begin
        step("jal", rb(), rb(), vec(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, im, 3'b000, 0));
        step("aluwb", rb(), rb(), vec(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 3'b000, 0));
      end
      default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        for (int k = 0; k < 3; k++) step("trap", rb(), rb(), vec(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1));
        do_reset();
`endif
      end
    endcase
  endtask

  initial begin
    logic [6:0] ops [7];
    logic [6:0] o;
    ops = '{LW, SW, RT, IT, BQ, JL, 7'b0000000};
    @(negedge clk);
    do_reset();
    run_instr(LW, 3'b010, 1'b0, 1'b0, 0, 2);
    run_instr(SW, 3'b010, 1'b0, 1'b0, 1, 0);
    run_instr(RT, 3'b000, 1'b1, 1'b0, 0, 0);
    run_instr(IT, 3'b000, 1'b1, 1'b0, 0, 0);
    run_instr(BQ, 3'b000, 1'b0, 1'b1, 0, 0);
    run_instr(BQ, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(JL, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0);
    op = LW;
    step("abort_fetch", 1'b1, 1'b0, vec(1, 0, 0, 1, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));
    step("abort_decode", 1'b1, 1'b0, vec(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0));
    step("abort_memadr", 1'b1, 1'b0, vec(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0));
    do_reset();
    for (int n = 0; n < 80; n++) begin
      o = ops[$urandom_range(0, 6)];
      if (o == 7'b0000000) begin
        o = 7'($urandom);
        if (is_legal(o)) o = 7'b0000000;
      end
      run_instr(o, 3'($urandom), rb(), rb(), $urandom_range(0, 2), $urandom_range(0, 2));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
